// File: rtl/snoop_responder_pkg.sv
// Shared types for the snoop responder: address and cache-line layout, MESI states,
// snoop operation/result encodings and a saturating counter helper.
package my_struct_package;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned TAG_W  = 12;
  localparam int unsigned SET_W  = 14;
  localparam int unsigned OFF_W  = 6;
  localparam int unsigned WAYS   = 8;
  localparam int unsigned IDX_W  = $clog2(WAYS);
  localparam int unsigned LRU_W  = 3;
  localparam int unsigned CNT_W  = 32;

  typedef enum logic [1:0] {
    MESI_I = 2'b00,
    MESI_S = 2'b01,
    MESI_E = 2'b10,
    MESI_M = 2'b11
  } mesi_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set;
    logic [OFF_W-1:0] offset;
  } address_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    mesi_t            mesi_bits;
    logic [LRU_W-1:0] lru;
  } cache_line_t;

  typedef enum logic [1:0] {
    READ       = 2'b00,
    WRITE      = 2'b01,
    INVALIDATE = 2'b10,
    RWIM       = 2'b11
  } snoop_op_t;

  typedef enum logic [1:0] {
    HIT   = 2'b00,
    HITM  = 2'b01,
    NOHIT = 2'b10
  } snoop_result_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/snoop_way_match.sv
// Combinational tag compare across the ways of one set: one-hot match,
// lowest matching way index and a flag when more than one way matches.
module snoop_way_match
  import my_struct_package::*;
(
  input  logic  [WAYS-1:0][TAG_W-1:0] way_tag,
  input  mesi_t [WAYS-1:0]            way_mesi,
  input  logic  [TAG_W-1:0]           tag,
  output logic  [WAYS-1:0]            match_c,
  output logic  [IDX_W-1:0]           sel_idx_c,
  output logic                        any_hit_c,
  output logic                        multi_hit_c
);

  always_comb begin
    match_c = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      match_c[w] = (way_mesi[w] != MESI_I) && (way_tag[w] == tag);
    end
  end

  // Scan downwards so the lowest matching way wins.
  always_comb begin
    sel_idx_c = '0;
    for (int w = int'(WAYS) - 1; w >= 0; w--) begin
      if (match_c[w]) sel_idx_c = IDX_W'(w);
    end
  end

  assign any_hit_c   = |match_c;
  assign multi_hit_c = |(match_c & (match_c - WAYS'(1)));

endmodule

// File: rtl/snoop_responder.sv
// MESI snoop responder: looks up a captured set, downgrades the hit way, optionally
// writes back a modified line. SNOOP_STATS_EN adds saturating result/write-back counters.
module snoop_responder
  import my_struct_package::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        snoop_valid,
  output logic                        snoop_ready,
  input  snoop_op_t                   snoop_op,
  input  address_t                    snoop_addr,
  input  cache_line_t [WAYS-1:0]      line_in,
  output cache_line_t [WAYS-1:0]      line_out,
  output logic                        line_we,
  output logic                        result_valid,
  output snoop_result_t               snoop_result,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [ADDR_W-1:0]           wb_addr,
  output logic                        protocol_err
`ifdef SNOOP_STATS_EN
  ,
  output logic [CNT_W-1:0]            cnt_hit,
  output logic [CNT_W-1:0]            cnt_hitm,
  output logic [CNT_W-1:0]            cnt_nohit,
  output logic [CNT_W-1:0]            cnt_wb
`endif
);

  typedef enum logic [1:0] {IDLE, LOOKUP, WRITEBACK, RESPOND} state_t;

  state_t                        state, next_state;
  snoop_op_t                     op_q;
  logic [TAG_W-1:0]              tag_q;
  logic [SET_W-1:0]              set_q;
  cache_line_t [WAYS-1:0]        line_q, line_next;
  logic [WAYS-1:0][TAG_W-1:0]    way_tag;
  mesi_t [WAYS-1:0]              way_mesi;
  logic [WAYS-1:0]               match;
  logic [IDX_W-1:0]              sel_idx;
  logic                          any_hit, multi_hit;
  mesi_t                         cur_mesi, new_mesi;
  snoop_result_t                 result_c;
  logic                          need_wb, err_c;
  logic                          unused_offset;

  assign unused_offset = ^snoop_addr.offset;

  always_comb begin
    way_tag  = '0;
    way_mesi = '{default: MESI_I};
    for (int unsigned w = 0; w < WAYS; w++) begin
      way_tag[w]  = line_q[w].tag;
      way_mesi[w] = line_q[w].mesi_bits;
    end
  end

  snoop_way_match u_match (
    .way_tag     (way_tag),
    .way_mesi    (way_mesi),
    .tag         (tag_q),
    .match_c     (match),
    .sel_idx_c   (sel_idx),
    .any_hit_c   (any_hit),
    .multi_hit_c (multi_hit)
  );

  // MESI transition, response and write-back decision for the selected way.
  always_comb begin
    cur_mesi = line_q[sel_idx].mesi_bits;
    new_mesi = cur_mesi;
    result_c = NOHIT;
    need_wb  = 1'b0;
    err_c    = multi_hit;
    if (any_hit) begin
      case (op_q)
        READ: begin
          case (cur_mesi)
            MESI_M:  begin new_mesi = MESI_S; need_wb = 1'b1; result_c = HITM; end
            MESI_E:  begin new_mesi = MESI_S; result_c = HIT; end
            MESI_S:  result_c = HIT;
            default: ;
          endcase
        end
        RWIM: begin
          case (cur_mesi)
            MESI_M:         begin new_mesi = MESI_I; need_wb = 1'b1; result_c = HITM; end
            MESI_E, MESI_S: begin new_mesi = MESI_I; result_c = HIT; end
            default: ;
          endcase
        end
        INVALIDATE: begin
          case (cur_mesi)
            MESI_M:         begin result_c = HITM; err_c = 1'b1; end
            MESI_E, MESI_S: begin new_mesi = MESI_I; result_c = HIT; end
            default: ;
          endcase
        end
        WRITE:   err_c = 1'b1;
        default: ;
      endcase
    end
    line_next = line_q;
    line_next[sel_idx].mesi_bits = new_mesi;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:      if (snoop_valid && snoop_ready) next_state = LOOKUP;
      LOOKUP:    next_state = need_wb ? WRITEBACK : RESPOND;
      WRITEBACK: if (wb_ready) next_state = RESPOND;
      RESPOND:   next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      snoop_ready  <= 1'b1;
      result_valid <= 1'b0;
      line_we      <= 1'b0;
      wb_valid     <= 1'b0;
      protocol_err <= 1'b0;
      snoop_result <= HIT;
      wb_addr      <= '0;
      line_out     <= '0;
      op_q         <= READ;
      tag_q        <= '0;
      set_q        <= '0;
      line_q       <= '0;
    end else begin
      state        <= next_state;
      snoop_ready  <= (next_state == IDLE);
      result_valid <= (next_state == RESPOND);
      line_we      <= (next_state == RESPOND);
      wb_valid     <= (next_state == WRITEBACK);
      protocol_err <= (state == LOOKUP) && err_c;
      if (state == IDLE && snoop_valid && snoop_ready) begin
        op_q   <= snoop_op;
        tag_q  <= snoop_addr.tag;
        set_q  <= snoop_addr.set;
        line_q <= line_in;
      end
      if (state == LOOKUP) begin
        line_out     <= line_next;
        snoop_result <= result_c;
        if (need_wb) wb_addr <= {tag_q, set_q, OFF_W'(0)};
      end
    end
  end

`ifdef SNOOP_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_hit   <= '0;
      cnt_hitm  <= '0;
      cnt_nohit <= '0;
      cnt_wb    <= '0;
    end else begin
      if (result_valid) begin
        case (snoop_result)
          HIT:     cnt_hit   <= sat_inc(cnt_hit);
          HITM:    cnt_hitm  <= sat_inc(cnt_hitm);
          NOHIT:   cnt_nohit <= sat_inc(cnt_nohit);
          default: ;
        endcase
      end
      if (wb_valid && wb_ready) cnt_wb <= sat_inc(cnt_wb);
    end
  end
`endif

endmodule

// File: tb/tb_snoop_responder.sv
// Directed self-checking bench for snoop_responder; counter checks are added when
// SNOOP_STATS_EN is defined.
module tb_snoop_responder;
  import my_struct_package::*;

  localparam logic [SET_W-1:0] SET = 14'h1234;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   snoop_valid;
  logic                   snoop_ready;
  snoop_op_t              snoop_op;
  address_t               snoop_addr;
  cache_line_t [WAYS-1:0] line_in;
  cache_line_t [WAYS-1:0] line_out;
  logic                   line_we;
  logic                   result_valid;
  snoop_result_t          snoop_result;
  logic                   wb_valid;
  logic                   wb_ready;
  logic [ADDR_W-1:0]      wb_addr;
  logic                   protocol_err;
`ifdef SNOOP_STATS_EN
  logic [CNT_W-1:0]       cnt_hit, cnt_hitm, cnt_nohit, cnt_wb;
`endif

  int checks = 0;
  int errors = 0;
  cache_line_t [WAYS-1:0] lines, exp_l;

  snoop_responder dut (
    .clk          (clk),
    .rst          (rst),
    .snoop_valid  (snoop_valid),
    .snoop_ready  (snoop_ready),
    .snoop_op     (snoop_op),
    .snoop_addr   (snoop_addr),
    .line_in      (line_in),
    .line_out     (line_out),
    .line_we      (line_we),
    .result_valid (result_valid),
    .snoop_result (snoop_result),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_addr      (wb_addr),
    .protocol_err (protocol_err)
`ifdef SNOOP_STATS_EN
    ,
    .cnt_hit      (cnt_hit),
    .cnt_hitm     (cnt_hitm),
    .cnt_nohit    (cnt_nohit),
    .cnt_wb       (cnt_wb)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic init_lines;
    for (int i = 0; i < int'(WAYS); i++) begin
      lines[i].tag = 12'h100 + TAG_W'(i);
      lines[i].lru = LRU_W'(i);
      if (i % 2 == 0) lines[i].mesi_bits = MESI_S;
      else            lines[i].mesi_bits = MESI_E;
    end
  endtask

  // One full snoop with wb_ready already driven; checks latency, response and line update.
  task automatic do_test(input string name, input snoop_op_t op, input logic [TAG_W-1:0] tag,
                         input int exp_lat, input snoop_result_t exp_res, input logic exp_wb,
                         input logic exp_err, input cache_line_t [WAYS-1:0] exp_lines);
    int lat;
    logic saw_wb, saw_err;
    logic [ADDR_W-1:0] wa, exp_wa;
    lat = 0; saw_wb = 1'b0; saw_err = 1'b0; wa = '0;
    exp_wa = exp_wb ? {tag, SET, 6'b0} : '0;
    snoop_op    = op;
    snoop_addr  = '{tag: tag, set: SET, offset: 6'h15};
    line_in     = lines;
    snoop_valid = 1'b1;
    tick;
    snoop_valid = 1'b0;
    line_in     = '1;
    while (result_valid !== 1'b1 && lat < 20) begin
      tick;
      lat++;
      if (wb_valid) begin saw_wb = 1'b1; wa = wb_addr; end
      if (protocol_err) saw_err = 1'b1;
      chk({name, "_busy"}, 136'(snoop_ready), 136'(1'b0));
    end
    chk({name, "_lat"}, 136'(lat), 136'(exp_lat));
    chk({name, "_res"}, 136'(snoop_result), 136'(exp_res));
    chk({name, "_we"}, 136'(line_we), 136'(1'b1));
    chk({name, "_line"}, 136'(line_out), 136'(exp_lines));
    chk({name, "_wb"}, 136'(saw_wb), 136'(exp_wb));
    chk({name, "_wbaddr"}, 136'(wa), 136'(exp_wa));
    chk({name, "_err"}, 136'(saw_err), 136'(exp_err));
    tick;
    chk({name, "_rv_off"}, 136'({result_valid, line_we}), 136'(2'b00));
    chk({name, "_ready"}, 136'(snoop_ready), 136'(1'b1));
  endtask

  initial begin
    rst = 1'b1; snoop_valid = 1'b0; wb_ready = 1'b1;
    snoop_op = READ; snoop_addr = '0; line_in = '0;
    tick; tick;
    chk("rst_ready", 136'(snoop_ready), 136'(1'b1));
    chk("rst_flags", 136'({result_valid, line_we, wb_valid, protocol_err}), 136'(4'b0));
    chk("rst_line", 136'(line_out), 136'(0));
    chk("rst_wbaddr_res", 136'({wb_addr, snoop_result}), 136'(0));
`ifdef SNOOP_STATS_EN
    chk("rst_cnt", 136'({cnt_hit, cnt_hitm, cnt_nohit, cnt_wb}), 136'(0));
`endif
    rst = 1'b0;
    tick;

    // Write-back stalled, new snoop held off, then reset abandons the operation.
    init_lines;
    lines[4] = '{tag: 12'h3C3, mesi_bits: MESI_M, lru: 3'd4};
    wb_ready = 1'b0;
    snoop_op = READ; snoop_addr = '{tag: 12'h3C3, set: SET, offset: 6'h00};
    line_in = lines; snoop_valid = 1'b1;
    tick;
    snoop_valid = 1'b0;
    tick;
    chk("stall_wbv0", 136'(wb_valid), 136'(1'b1));
    snoop_valid = 1'b1; snoop_op = RWIM;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("stall_wbv", 136'(wb_valid), 136'(1'b1));
      chk("stall_wbaddr", 136'(wb_addr), 136'({12'h3C3, SET, 6'b0}));
      chk("stall_ready", 136'({snoop_ready, result_valid}), 136'(2'b00));
    end
    rst = 1'b1;
    tick;
    chk("abort_ready", 136'(snoop_ready), 136'(1'b1));
    chk("abort_flags", 136'({result_valid, line_we, wb_valid, protocol_err}), 136'(4'b0));
    chk("abort_line", 136'(line_out), 136'(0));
    rst = 1'b0; snoop_valid = 1'b0; wb_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("abort_idle", 136'({snoop_ready, result_valid, line_we}), 136'(3'b100));
    end

    init_lines; lines[3] = '{tag: 12'hABC, mesi_bits: MESI_M, lru: 3'd3};
    exp_l = lines; exp_l[3].mesi_bits = MESI_S;
    do_test("rd_m", READ, 12'hABC, 2, HITM, 1'b1, 1'b0, exp_l);

    init_lines; lines[5] = '{tag: 12'h555, mesi_bits: MESI_E, lru: 3'd5};
    exp_l = lines; exp_l[5].mesi_bits = MESI_I;
    do_test("rwim_e", RWIM, 12'h555, 1, HIT, 1'b0, 1'b0, exp_l);

    init_lines;
    do_test("rd_miss", READ, 12'h777, 1, NOHIT, 1'b0, 1'b0, lines);

    init_lines; lines[1] = '{tag: 12'h1A1, mesi_bits: MESI_I, lru: 3'd1};
    do_test("rd_inv", READ, 12'h1A1, 1, NOHIT, 1'b0, 1'b0, lines);

    init_lines; lines[0] = '{tag: 12'h0AA, mesi_bits: MESI_M, lru: 3'd0};
    do_test("inv_m", INVALIDATE, 12'h0AA, 1, HITM, 1'b0, 1'b1, lines);

    init_lines; exp_l = lines; exp_l[1].mesi_bits = MESI_S;
    do_test("rd_e", READ, 12'h101, 1, HIT, 1'b0, 1'b0, exp_l);

    init_lines;
    do_test("rd_s", READ, 12'h102, 1, HIT, 1'b0, 1'b0, lines);

    init_lines; lines[6] = '{tag: 12'h6C6, mesi_bits: MESI_M, lru: 3'd6};
    exp_l = lines; exp_l[6].mesi_bits = MESI_I;
    do_test("rwim_m", RWIM, 12'h6C6, 2, HITM, 1'b1, 1'b0, exp_l);

    init_lines; exp_l = lines; exp_l[4].mesi_bits = MESI_I;
    do_test("inv_s", INVALIDATE, 12'h104, 1, HIT, 1'b0, 1'b0, exp_l);

    init_lines;
    do_test("wr_hit", WRITE, 12'h103, 1, NOHIT, 1'b0, 1'b1, lines);

    init_lines;
    lines[2] = '{tag: 12'h001, mesi_bits: MESI_E, lru: 3'd2};
    lines[6] = '{tag: 12'h001, mesi_bits: MESI_E, lru: 3'd6};
    exp_l = lines; exp_l[2].mesi_bits = MESI_S;
    do_test("multi", READ, 12'h001, 1, HIT, 1'b0, 1'b1, exp_l);

    // Write-back accepted after a few stalled cycles: result follows the handshake by one cycle.
    init_lines; lines[7] = '{tag: 12'h8E8, mesi_bits: MESI_M, lru: 3'd7};
    exp_l = lines; exp_l[7].mesi_bits = MESI_S;
    wb_ready = 1'b0;
    snoop_op = READ; snoop_addr = '{tag: 12'h8E8, set: SET, offset: 6'h3F};
    line_in = lines; snoop_valid = 1'b1;
    tick;
    snoop_valid = 1'b0; line_in = '0;
    tick;
    chk("dly_wbv", 136'(wb_valid), 136'(1'b1));
    tick; tick;
    chk("dly_hold", 136'({wb_valid, result_valid}), 136'(2'b10));
    chk("dly_wbaddr", 136'(wb_addr), 136'({12'h8E8, SET, 6'b0}));
    wb_ready = 1'b1;
    tick;
    chk("dly_rv", 136'({result_valid, line_we, wb_valid}), 136'(3'b110));
    chk("dly_res", 136'(snoop_result), 136'(HITM));
    chk("dly_line", 136'(line_out), 136'(exp_l));
    tick;
    chk("dly_rv_off", 136'(result_valid), 136'(1'b0));

`ifdef SNOOP_STATS_EN
    tick;
    chk("cnt_hit", 136'(cnt_hit), 136'(32'd5));
    chk("cnt_hitm", 136'(cnt_hitm), 136'(32'd4));
    chk("cnt_nohit", 136'(cnt_nohit), 136'(32'd3));
    chk("cnt_wb", 136'(cnt_wb), 136'(32'd3));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/snoop_responder.md
SNOOP_RESPONDER -- requirements
Module: snoop_responder

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge clk.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port snoop_valid, input, 1 bit: a snooped bus operation is offered.
REQ-004 SHALL have port snoop_ready, output, 1 bit: the responder accepts an operation; high only in IDLE.
REQ-005 SHALL have port snoop_op, input, snoop_op_t: the bus operation, one of READ, WRITE, INVALIDATE, RWIM.
REQ-006 SHALL have port snoop_addr, input, address_t: 32-bit address split as tag[31:20], set[19:6], offset[5:0].
REQ-007 SHALL have port line_in, input, cache_line_t[8]: the 8 data-cache ways of the addressed set.
REQ-008 SHALL have port line_out, output, cache_line_t[8]: the updated ways of the same set.
REQ-009 SHALL have port line_we, output, 1 bit: one-cycle strobe; the owner writes line_out back to the set.
REQ-010 SHALL have port result_valid, output, 1 bit: one-cycle strobe qualifying snoop_result.
REQ-011 SHALL have port snoop_result, output, snoop_result_t: HIT=2'b00, HITM=2'b01, NOHIT=2'b10.
REQ-012 SHALL have port wb_valid, output, 1 bit: request to put the modified line on the bus.
REQ-013 SHALL have port wb_ready, input, 1 bit: the bus accepts the write-back.
REQ-014 SHALL have port wb_addr, output, 32 bits: {tag, set, 6'b0} of the written-back line.
REQ-015 SHALL have port protocol_err, output, 1 bit: one-cycle pulse on an illegal coherence condition.

Function
REQ-016 SHALL implement the FSM states IDLE, LOOKUP, WRITEBACK and RESPOND.
REQ-017 In IDLE, snoop_valid&&snoop_ready SHALL capture snoop_op, snoop_addr and line_in, then go to LOOKUP.
REQ-018 LOOKUP SHALL set a one-hot match over ways where MESI_bits!=I and tag equals the captured tag.
REQ-019 More than one matching way SHALL select the lowest index and pulse protocol_err.
REQ-020 READ SHALL map: M->S with write-back, result HITM; E->S, result HIT; S stays, result HIT; no match gives NOHIT.
REQ-021 RWIM SHALL map: M->I with write-back, result HITM; E or S->I, result HIT; no match gives NOHIT.
REQ-022 INVALIDATE SHALL map: S->I, result HIT; E->I, result HIT; M unchanged, result HITM with protocol_err and no write-back; no match gives NOHIT.
REQ-023 WRITE SHALL make no state change and return result NOHIT; a match on it SHALL pulse protocol_err.
REQ-024 Snoops SHALL never modify tag or LRU fields.
REQ-025 When a write-back is required, LOOKUP SHALL go to WRITEBACK; otherwise it SHALL go to RESPOND.
REQ-026 WRITEBACK SHALL hold wb_valid and a stable wb_addr until the cycle where wb_valid&&wb_ready, then go to RESPOND.
REQ-027 RESPOND SHALL assert result_valid and line_we for exactly one cycle, then return to IDLE.
REQ-028 Latency SHALL be: accept at cycle T gives result at T+2 without write-back, and W+1 with write-back, where W is the wb handshake cycle.
REQ-029 While not in IDLE, snoop_valid SHALL be ignored and held off by snoop_ready=0.
REQ-030 line_out SHALL equal the captured line_in with only the selected way's MESI_bits changed; on no match it SHALL be unchanged.

Reset
REQ-031 rst SHALL force IDLE and drive snoop_ready=1 and all other outputs to 0, including line_out.
REQ-032 rst asserted mid-operation, including during WRITEBACK, SHALL abandon the operation with no line_we and no result_valid.
REQ-033 rst SHALL take precedence over a simultaneous accept.

Configuration
REQ-034 With SNOOP_STATS_EN defined, the block SHALL add 32-bit outputs cnt_hit, cnt_hitm, cnt_nohit, cnt_wb.
REQ-035 These counters SHALL increment on result_valid or on a wb handshake, saturate at 32'hFFFF_FFFF and clear on rst.
REQ-036 Without SNOOP_STATS_EN, the counter ports and logic SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-037 my_struct_package SHALL hold snoop_op_t, snoop_result_t and the TAG_W=12, SET_W=14 and WAYS=8 constants, reusing cache_line_t, address_t and the MESI encoding.
REQ-038 The block SHALL contain one sub-module, snoop_way_match (combinational), producing the one-hot match, the selected index and a multi-hit flag.

Verification
REQ-039 READ, tag 12'hABC, way 3=M, wb_ready tied 1: wb_addr={12'hABC,set,6'b0} -> HITM; way 3 becomes S; result at T+3.
REQ-040 RWIM hits way 5=E: no wb_valid; HIT at T+2; way 5 becomes I; other ways bit-identical.
REQ-041 READ with no tag match, or a match only on an I way: NOHIT at T+2; line_out==line_in.
REQ-042 INVALIDATE hits way 0=M: HITM; protocol_err pulses; way 0 stays M; no wb_valid.
REQ-043 Write-back with wb_ready low for 4 cycles: wb_valid and wb_addr stable; a new snoop_valid is not accepted; rst in cycle 2 gives IDLE with no line_we.
REQ-044 Tag 12'h001 matches valid ways 2 and 6: way 2 is updated and protocol_err pulses; with SNOOP_STATS_EN the counters match the expected totals.
